rv32_alu_addsub_pipe: RTL
=========================

# rv32_alu_addsub_pipe

Parametrised, pipelined add/subtract unit for the RV32 ALU datapath, successor to the combinational add/sub submodule. Keeps the same `alu_opsel` add/sub decode, generalises the operand width, and registers the result through `STAGES` elastic pipeline stages with a valid/ready handshake. It also carries a sideband tag, produces arithmetic flags, and supports a pipeline flush. It sits between operand select (RS/RT/PC/IMM muxes) and the ALU result mux/writeback.

## Interface
- `XLEN`, default 32: operand/result width; legal range is 8 or more.
- `STAGES`, default 2: number of pipeline register stages; legal range is 1–4.
- `TAG_W`, default 5: width of the sideband tag, for example the rd index.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `flush` input, 1 bit: synchronously invalidates every stage.
- `in_valid` input, 1 bit: an operation is presented.
- `in_ready` output, 1 bit: the unit accepts the operation this cycle.
- `alu_opsel` input, 4 bits: operation select.
- `opA` input, `XLEN` bits: operand A.
- `opB` input, `XLEN` bits: operand B.
- `in_tag` input, `TAG_W` bits: tag carried with the operation.
- `out_valid` output, 1 bit: a result is presented.
- `out_ready` input, 1 bit: the consumer takes the result this cycle.
- `result` output, `XLEN` bits: sum, difference, or 0.
- `out_tag` output, `TAG_W` bits: tag of the presented result.
- `flag_z` output, 1 bit: zero flag.
- `flag_n` output, 1 bit: negative flag.
- `flag_c` output, 1 bit: carry (add) or borrow (sub).
- `flag_v` output, 1 bit: signed overflow.
- `unsup` output, 1 bit: `alu_opsel` was not an add or sub code.

## Operation
- **Decode**
  - Add for `alu_opsel` ∈ {0, 7, 15}.
  - Sub for `alu_opsel` ∈ {1, 8}.
  - Any other code sets `unsup`=1 with `result`=0 and all four flags 0. The operation still flows through the pipe and returns a valid response.
- **Arithmetic**, computed in stage 1 at `XLEN+1` bits; `result` is the low `XLEN` bits.
  - Add: `flag_c` is bit `XLEN` of the sum.
  - Add: `flag_v` is set when `opA[MSB]`==`opB[MSB]` and `result[MSB]`≠`opA[MSB]`.
  - Sub: `flag_c` is the borrow, equal to (`opA` < `opB` unsigned).
  - Sub: `flag_v` is set when `opA[MSB]`≠`opB[MSB]` and `result[MSB]`≠`opA[MSB]`.
  - `flag_z` = (`result`==0) and `flag_n` = `result[MSB]`, for add/sub only.
- **Pipeline**
  - Stage k holds valid bit `v[k]` plus the payload: `result`, the flags, `unsup`, and the tag.
  - The outputs are driven directly from the last stage.
  - Stage k advances when `v[k]`=0 or stage k+1 advances. The last stage advances when `v[last]`=0 or `out_ready`=1.
  - `in_ready` = stage 1 advances and `flush`=0.
  - Accept means `in_valid`&&`in_ready`.
  - Bubbles collapse, so a stalled downstream does not block empty upstream stages.
  - Throughput is one operation per cycle when `out_ready` is held high.
  - Payload registers load only on advance. The output payload is stable while `out_valid`=1 and `out_ready`=0.
- **Flush**
  - The cycle after `flush`=1, all `v[k]`=0.
  - `in_ready` is 0 during the flush cycle, so no operation is accepted.
  - An output handshake completing in the flush cycle is still counted as consumed.
- **Reset**
  - On `rst`=1, all `v[k]` and all payload registers clear to 0, and `in_ready` is 0.
  - Reset takes precedence over `flush` and over accept.

## Timing
- **After reset:** `out_valid`=0, `result`=0, `out_tag`=0, all flags=0, `unsup`=0.
- **Latency:** an operation accepted at edge N appears with `out_valid`=1 after edge N+`STAGES-1`, when there are no stalls. With `STAGES`=1, the result is visible the cycle after accept.
- **Stalls:** when `out_ready`=0 with all stages full, `in_ready` falls combinationally in the same cycle. No operation is dropped or duplicated.
- **Full-pipe throughput:** when `out_ready` rises with all stages full, a new operation is accepted in the same cycle.
- **Combinational paths:** `out_ready` to `in_ready` is a combinational path. There is no combinational path from `opA`/`opB` to any output.
- **Ordering:** operations leave in acceptance order, and tags are never reordered.

## Test plan
- **Reset:** `rst` high for 2 cycles mid-stream with 2 operations in flight, then low -> `out_valid`=0, all outputs 0; the in-flight operations never appear.
- **Add with overflow:** `XLEN`=32, opsel 0, `opA`=0x7FFFFFFF, `opB`=1, tag 3 -> after `STAGES` cycles: `result`=0x80000000, `flag_v`=1, `flag_n`=1, `flag_c`=0, `flag_z`=0, `out_tag`=3.
  - Same with opsel 7, `opA`=0xFFFFFFFF, `opB`=1 -> `result`=0, `flag_z`=1, `flag_c`=1, `flag_v`=0.
- **Sub and unsupported:** opsel 8, `opA`=2, `opB`=5 -> `result`=0xFFFFFFFD, `flag_c`=1 (borrow), `flag_n`=1, `flag_v`=0.
  - opsel 1, `opA`=0x80000000, `opB`=1 -> `result`=0x7FFFFFFF, `flag_v`=1.
  - opsel 3 -> `result`=0, flags 0, `unsup`=1, `out_valid` asserted.
- **Back-pressure:** stream tags 0..9 with `out_ready` toggled by a pseudo-random pattern -> all 10 results exit in order with correct sums, and `in_ready`=0 only when all stages are full and `out_ready`=0. With `out_ready` held at 1, the stream sustains 1 operation per cycle.
- **Flush:** fill the pipe (`STAGES`=3, tags 1–3), assert `flush` for one cycle with `in_valid`=1 and tag 4 -> no operations with tags 1–4 appear; tag 5 sent next cycle emerges alone with the correct result.
- **Parameter sweep:** `XLEN`=8 and `STAGES`=1 and 4 -> add `opA`=0xFF, `opB`=0x01 gives `result`=0x00, `flag_c`=1, `flag_z`=1, at latency 1 and 4 respectively.

Source files
------------

// File: rtl/rv32_alu_addsub_pipe.sv
// Pipelined RV32 add/sub unit: stage 1 decodes alu_opsel and computes result and flags at XLEN+1 bits.
// STAGES elastic registers with valid/ready, sideband tag and synchronous flush.
module rv32_alu_addsub_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_opsel,
  input  logic [XLEN-1:0]  opA,
  input  logic [XLEN-1:0]  opB,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             unsup
);

  localparam int MSB = XLEN - 1;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic             unsup;
    logic [TAG_W-1:0] tag;
  } pld_t;

  function automatic pld_t addsub_calc(input logic [3:0]       sel,
                                       input logic [XLEN-1:0]  a,
                                       input logic [XLEN-1:0]  b,
                                       input logic [TAG_W-1:0] tag);
    pld_t            p;
    logic [XLEN:0]   w;
    logic            is_add;
    logic            is_sub;
    is_add = (sel == 4'd0) || (sel == 4'd7) || (sel == 4'd15);
    is_sub = (sel == 4'd1) || (sel == 4'd8);
    p      = '0;
    p.tag  = tag;
    // Bit XLEN is the carry for add and the unsigned borrow for sub.
    w = is_sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    if (is_add || is_sub) begin
      p.res = w[XLEN-1:0];
      p.c   = w[XLEN];
      p.z   = (w[XLEN-1:0] == '0);
      p.n   = w[MSB];
      p.v   = (is_add ? (a[MSB] == b[MSB]) : (a[MSB] != b[MSB])) && (w[MSB] != a[MSB]);
    end else begin
      p.unsup = 1'b1;
    end
    return p;
  endfunction

  logic [STAGES-1:0] r_vld_p;
  pld_t              r_pld_p [STAGES];
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_vld_in;
  pld_t              w_pld_in [STAGES];
  pld_t              w_calc;
  logic              w_acc;

  // A stage advances unless it and every stage after it are full while the consumer stalls.
  always_comb begin : adv_logic
    logic w_full;
    w_adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_full = 1'b1;
      for (int j = k; j < STAGES; j++) w_full = w_full & r_vld_p[j];
      w_adv[k] = !w_full || out_ready;
    end
  end

  assign in_ready = w_adv[0] & ~flush & ~rst;
  assign w_acc    = in_valid & in_ready;
  assign w_calc   = addsub_calc(alu_opsel, opA, opB, in_tag);

  always_comb begin
    w_vld_in    = '0;
    w_vld_in[0] = w_acc;
    w_pld_in[0] = w_calc;
    for (int k = 1; k < STAGES; k++) begin
      w_vld_in[k] = r_vld_p[k-1];
      w_pld_in[k] = r_pld_p[k-1];
    end
  end

  // Stage boundary: every pipeline register, input side at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p <= '0;
      for (int k = 0; k < STAGES; k++) r_pld_p[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush)         r_vld_p[k] <= 1'b0;
        else if (w_adv[k]) r_vld_p[k] <= w_vld_in[k];
        if (w_adv[k])      r_pld_p[k] <= w_pld_in[k];
      end
    end
  end

  assign out_valid = r_vld_p[STAGES-1];
  assign result    = r_pld_p[STAGES-1].res;
  assign out_tag   = r_pld_p[STAGES-1].tag;
  assign flag_z    = r_pld_p[STAGES-1].z;
  assign flag_n    = r_pld_p[STAGES-1].n;
  assign flag_c    = r_pld_p[STAGES-1].c;
  assign flag_v    = r_pld_p[STAGES-1].v;
  assign unsup     = r_pld_p[STAGES-1].unsup;

endmodule
